// File: rtl/xadc_sample_avg.sv
// XADC DRP sampler: one DRP read of CH_SEL per matching eoc, averages 2^AVG_LOG2 results; THRESH_EN adds the above_out hysteresis comparator.
// Latency eoc->den 1 cycle, drdy->avg_valid 2 cycles; no backpressure, a matching eoc while busy is dropped and flagged on overrun.
module xadc_sample_avg #(
    parameter int          AVG_LOG2 = 4,
    parameter logic [4:0]  CH_SEL   = 5'h10,
    parameter int          TIMEOUT  = 63,
    parameter logic [11:0] THR_HI   = 12'hA00,
    parameter logic [11:0] THR_LO   = 12'h600
) (
    input  logic        dclk_in,
    input  logic        reset_in,
    input  logic        eoc_in,
    input  logic [4:0]  channel_in,
    input  logic        drdy_in,
    input  logic [15:0] do_in,
    output logic        den_out,
    output logic        dwe_out,
    output logic [6:0]  daddr_out,
    output logic [15:0] di_out,
    output logic [11:0] avg_out,
    output logic        avg_valid,
    output logic        timeout_err,
    output logic        overrun,
    output logic        above_out
);

    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    // Timer reads k-1 in the k-th WAIT cycle, so this gives drdy cycles 1..TIMEOUT after den.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ACC} state_t;

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [TMR_W-1:0] r_timer;
    logic [11:0]      r_sample;
    logic [11:0]      r_avg;
    logic             r_den;
    logic             r_avg_vld;
    logic             r_tmo;
    logic             r_ovr;

    logic             w_eoc_hit;
    logic [ACC_W-1:0] w_sum;
    logic [11:0]      w_avg;
    logic             w_last;
    logic             w_unused;

    assign w_eoc_hit = eoc_in && (channel_in == CH_SEL);
    assign w_sum     = r_acc + ACC_W'(r_sample);
    assign w_avg     = w_sum[ACC_W-1:AVG_LOG2];
    assign w_last    = (r_cnt == CNT_LAST);

`ifdef THRESH_EN
    logic r_above;
    assign above_out = r_above;
    assign w_unused  = &{1'b0, do_in[3:0]};
`else
    assign above_out = 1'b0;
    assign w_unused  = &{1'b0, do_in[3:0], THR_HI, THR_LO};
`endif

    always_ff @(posedge dclk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_timer   <= '0;
            r_sample  <= '0;
            r_avg     <= '0;
            r_den     <= 1'b0;
            r_avg_vld <= 1'b0;
            r_tmo     <= 1'b0;
            r_ovr     <= 1'b0;
`ifdef THRESH_EN
            r_above   <= 1'b0;
`endif
        end else begin
            r_den     <= 1'b0;
            r_avg_vld <= 1'b0;
            r_tmo     <= 1'b0;
            r_ovr     <= w_eoc_hit && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_eoc_hit) begin
                        r_den   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // drdy wins over the timeout on the last allowed cycle
                    if (drdy_in) begin
                        r_sample <= do_in[15:4];
                        r_state  <= S_ACC;
                    end else if (r_timer == TMR_LAST) begin
                        r_tmo   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                S_ACC: begin
                    if (w_last) begin
                        r_avg     <= w_avg;
                        r_avg_vld <= 1'b1;
                        r_acc     <= '0;
                        r_cnt     <= '0;
`ifdef THRESH_EN
                        if (w_avg >= THR_HI) begin
                            r_above <= 1'b1;
                        end else if (w_avg <= THR_LO) begin
                            r_above <= 1'b0;
                        end
`endif
                    end else begin
                        r_acc <= w_sum;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign den_out     = r_den;
    assign dwe_out     = 1'b0;
    assign daddr_out   = {2'b00, CH_SEL};
    assign di_out      = 16'h0000;
    assign avg_out     = r_avg;
    assign avg_valid   = r_avg_vld;
    assign timeout_err = r_tmo;
    assign overrun     = r_ovr;

endmodule

// File: tb/tb_xadc_sample_avg.sv
// Directed bench: instance a averages 4 samples, instance b (AVG_LOG2=0) passes every sample and exercises THRESH_EN.
module tb_xadc_sample_avg;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_eoc, b_eoc;
    logic [4:0]  ch;
    logic        drdy;
    logic [15:0] dat;

    logic        a_den, a_dwe, a_vld, a_tmo, a_ovr, a_above;
    logic [6:0]  a_daddr;
    logic [15:0] a_di;
    logic [11:0] a_avg;
    logic        b_den, b_dwe, b_vld, b_tmo, b_ovr, b_above;
    logic [6:0]  b_daddr;
    logic [15:0] b_di;
    logic [11:0] b_avg;

    logic        sel;
    logic        den_s, vld_s;
    logic [6:0]  daddr_s;
    logic [11:0] avg_s;
    logic [3:0]  above_exp;

    int n_checks;
    int n_err;
    int early;

    always #5 clk = ~clk;

    assign den_s   = sel ? b_den   : a_den;
    assign vld_s   = sel ? b_vld   : a_vld;
    assign daddr_s = sel ? b_daddr : a_daddr;
    assign avg_s   = sel ? b_avg   : a_avg;

    xadc_sample_avg #(.AVG_LOG2(2)) u_a (
        .dclk_in(clk), .reset_in(rst), .eoc_in(a_eoc), .channel_in(ch),
        .drdy_in(drdy), .do_in(dat), .den_out(a_den), .dwe_out(a_dwe),
        .daddr_out(a_daddr), .di_out(a_di), .avg_out(a_avg), .avg_valid(a_vld),
        .timeout_err(a_tmo), .overrun(a_ovr), .above_out(a_above)
    );

    xadc_sample_avg #(.AVG_LOG2(0)) u_b (
        .dclk_in(clk), .reset_in(rst), .eoc_in(b_eoc), .channel_in(ch),
        .drdy_in(drdy), .do_in(dat), .den_out(b_den), .dwe_out(b_dwe),
        .daddr_out(b_daddr), .di_out(b_di), .avg_out(b_avg), .avg_valid(b_vld),
        .timeout_err(b_tmo), .overrun(b_ovr), .above_out(b_above)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    // One full read: eoc, den check, drdy two cycles later, avg_valid two cycles after drdy.
    task automatic do_sample(input logic s, input logic [15:0] d, input logic ev,
                             input logic [11:0] ea, input string tag);
        sel = s;
        ch  = 5'h10;
        if (s) b_eoc = 1'b1; else a_eoc = 1'b1;
        @(negedge clk);
        a_eoc = 1'b0;
        b_eoc = 1'b0;
        chk({tag, "_den1"}, 32'(den_s), 1);
        chk({tag, "_daddr"}, 32'(daddr_s), 32'h10);
        @(negedge clk);
        chk({tag, "_den0"}, 32'(den_s), 0);
        drdy = 1'b1;
        dat  = d;
        @(negedge clk);
        drdy = 1'b0;
        chk({tag, "_vld_early"}, 32'(vld_s), 0);
        @(negedge clk);
        chk({tag, "_vld"}, 32'(vld_s), 32'(ev));
        if (ev) chk({tag, "_avg"}, 32'(avg_s), 32'(ea));
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        sel      = 1'b0;
        rst      = 1'b1;
        a_eoc    = 1'b0;
        b_eoc    = 1'b0;
        ch       = 5'h00;
        drdy     = 1'b0;
        dat      = 16'h0000;
`ifdef THRESH_EN
        above_exp = 4'b0110;
`else
        above_exp = 4'b0000;
`endif
        repeat (3) @(negedge clk);
        chk("rst_den", 32'(a_den), 0);
        chk("rst_dwe", 32'(a_dwe), 0);
        chk("rst_di", 32'(a_di), 0);
        chk("rst_daddr", 32'(a_daddr), 32'h10);
        chk("rst_avg", 32'(a_avg), 0);
        chk("rst_vld", 32'(a_vld), 0);
        chk("rst_tmo", 32'(a_tmo), 0);
        chk("rst_ovr", 32'(a_ovr), 0);
        chk("rst_above", 32'(a_above), 0);
        chk("rst_b_dwe_di", 32'({b_dwe, b_di}), 0);
        rst = 1'b0;
        @(negedge clk);

        // 0x100+0x200+0x300+0x400 = 0xA00, /4 = 0x280
        do_sample(1'b0, 16'h1000, 1'b0, 12'h000, "avg_s0");
        do_sample(1'b0, 16'h2000, 1'b0, 12'h000, "avg_s1");
        do_sample(1'b0, 16'h3000, 1'b0, 12'h000, "avg_s2");
        do_sample(1'b0, 16'h4000, 1'b1, 12'h280, "avg_s3");
        @(negedge clk);
        chk("hold_vld", 32'(a_vld), 0);
        chk("hold_avg", 32'(a_avg), 32'h280);

        // Foreign channel is ignored silently
        a_eoc = 1'b1;
        ch    = 5'h03;
        @(negedge clk);
        a_eoc = 1'b0;
        chk("foreign_den", 32'(a_den), 0);
        @(negedge clk);
        chk("foreign_den2", 32'(a_den), 0);
        chk("foreign_ovr", 32'(a_ovr), 0);

        // Timeout between first and second sample; count must not advance
        do_sample(1'b0, 16'h1000, 1'b0, 12'h000, "to_s0");
        a_eoc = 1'b1;
        ch    = 5'h10;
        @(negedge clk);
        a_eoc = 1'b0;
        chk("to_den", 32'(a_den), 1);
        early = 0;
        for (int k = 1; k <= 63; k++) begin
            @(negedge clk);
            if (a_tmo || a_den || a_ovr) early++;
        end
        chk("to_quiet_window", 32'(early), 0);
        @(negedge clk);
        chk("to_pulse", 32'(a_tmo), 1);
        @(negedge clk);
        chk("to_pulse_end", 32'(a_tmo), 0);
        // 0x100+0x200+0x300+0x4F0 = 0xAF0, /4 = 0x2BC
        do_sample(1'b0, 16'h2000, 1'b0, 12'h000, "to_s1");
        do_sample(1'b0, 16'h3000, 1'b0, 12'h000, "to_s2");
        do_sample(1'b0, 16'h4F00, 1'b1, 12'h2BC, "to_s3");

        // Matching eoc one cycle after den: dropped, in-flight read completes
        a_eoc = 1'b1;
        ch    = 5'h10;
        @(negedge clk);
        a_eoc = 1'b0;
        chk("ovr_den", 32'(a_den), 1);
        @(negedge clk);
        a_eoc = 1'b1;
        drdy  = 1'b1;
        dat   = 16'h0400;
        @(negedge clk);
        a_eoc = 1'b0;
        drdy  = 1'b0;
        chk("ovr_pulse", 32'(a_ovr), 1);
        chk("ovr_no_den", 32'(a_den), 0);
        @(negedge clk);
        chk("ovr_pulse_end", 32'(a_ovr), 0);
        chk("ovr_no_den2", 32'(a_den), 0);
        do_sample(1'b0, 16'h0400, 1'b0, 12'h000, "ovr_s1");
        do_sample(1'b0, 16'h0400, 1'b0, 12'h000, "ovr_s2");
        do_sample(1'b0, 16'h0400, 1'b1, 12'h040, "ovr_s3");

        // Reset during WAIT with a partial accumulation pending
        do_sample(1'b0, 16'hFF00, 1'b0, 12'h000, "rw_s0");
        a_eoc = 1'b1;
        ch    = 5'h10;
        @(negedge clk);
        a_eoc = 1'b0;
        chk("rw_den", 32'(a_den), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rw_avg", 32'(a_avg), 0);
        chk("rw_outs", 32'({a_den, a_vld, a_tmo, a_ovr, a_above}), 0);
        @(negedge clk);
        @(negedge clk);
        drdy = 1'b1;
        dat  = 16'hFFF0;
        @(negedge clk);
        drdy = 1'b0;
        early = 0;
        for (int k = 0; k < 4; k++) begin
            if (a_vld || a_den || a_tmo || a_ovr || (a_avg != 12'h000)) early++;
            @(negedge clk);
        end
        chk("rw_late_drdy", 32'(early), 0);
        do_sample(1'b0, 16'h1000, 1'b0, 12'h000, "rw_s1");
        do_sample(1'b0, 16'h2000, 1'b0, 12'h000, "rw_s2");
        do_sample(1'b0, 16'h3000, 1'b0, 12'h000, "rw_s3");
        do_sample(1'b0, 16'h4000, 1'b1, 12'h280, "rw_s4");

        // AVG_LOG2=0 passes every sample; hysteresis 0,1,1,0 when THRESH_EN
        do_sample(1'b1, 16'h7000, 1'b1, 12'h700, "th0");
        chk("th0_above", 32'(b_above), 32'(above_exp[0]));
        do_sample(1'b1, 16'hA000, 1'b1, 12'hA00, "th1");
        chk("th1_above", 32'(b_above), 32'(above_exp[1]));
        do_sample(1'b1, 16'h8000, 1'b1, 12'h800, "th2");
        chk("th2_above", 32'(b_above), 32'(above_exp[2]));
        do_sample(1'b1, 16'h6000, 1'b1, 12'h600, "th3");
        chk("th3_above", 32'(b_above), 32'(above_exp[3]));

        // drdy on the last allowed cycle (63 after den) is accepted
        sel   = 1'b1;
        b_eoc = 1'b1;
        ch    = 5'h10;
        @(negedge clk);
        b_eoc = 1'b0;
        chk("edge_den", 32'(b_den), 1);
        repeat (63) @(negedge clk);
        drdy = 1'b1;
        dat  = 16'h1230;
        @(negedge clk);
        drdy = 1'b0;
        chk("edge_no_tmo", 32'(b_tmo), 0);
        @(negedge clk);
        chk("edge_vld", 32'(b_vld), 1);
        chk("edge_avg", 32'(b_avg), 32'h123);
        chk("edge_no_tmo2", 32'(b_tmo), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
